// File: rtl/sem_icap_pkg.sv
// Shared definitions for the SEM-side ICAP ownership controller.
// Holds the sem_status bit positions, the status width and the
// ownership FSM state type (encoding is visible on owner_state_o).
package sem_icap_pkg;

  localparam int unsigned StatusW = 9;

  // Bit positions inside sem_status
  localparam int unsigned StInit        = 0;
  localparam int unsigned StObservation = 1;
  localparam int unsigned StCorrection  = 2;
  localparam int unsigned StClassif     = 3;
  localparam int unsigned StInjection   = 4;
  localparam int unsigned StEssential   = 5;
  localparam int unsigned StUncorr      = 6;
  localparam int unsigned StDiagScan    = 7;
  localparam int unsigned StDetectOnly  = 8;

  typedef enum logic [1:0] {
    OwnIdle = 2'b00,
    OwnReq  = 2'b01,
    OwnHeld = 2'b10
  } own_state_e;

endpackage

// File: rtl/sem_cmd_fifo.sv
// Synchronous command FIFO with a registered read pointer.
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   push_i, wdata_i  write request and data (accepted when not full, or full with a pop)
//   pop_i            read request (ignored when empty)
//   rdata_o          head entry (valid while !empty_o)
//   full_o, empty_o  occupancy flags
module sem_cmd_fifo #(
  parameter int unsigned Width = 44,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sem_icap_handoff.sv
// SEM-side ICAP ownership controller sitting between the SEM core and the shared
// ICAP arbiter. Tracks ICAP ownership, qualifies releases, paces queued SEM
// commands and watches per-SLR heartbeats.
// Ports:
//   icap_clk_i, reset_i                  clock, synchronous active-high reset
//   sem_en_i, sem_cap_req_i              enable and SEM cap_req
//   sem_cap_gnt_o, sem_cap_rel_o         grant passthrough, registered qualified release
//   icap_req_o, icap_gnt_i, icap_rel_i   arbiter handshake
//   sem_status_i                         SEM status vector (see sem_icap_pkg)
//   slr_heartbeat_i, hb_clear_i, hb_lost_o   heartbeat watchdog
//   cmd_valid_i, cmd_code_i, cmd_ready_o     command queue input
//   sem_command_strobe_o, sem_command_code_o, sem_command_busy_i  command issue to SEM
//   idle_flag_o, owner_state_o           idle indication and FSM debug
module sem_icap_handoff
  import sem_icap_pkg::*;
#(
  parameter int unsigned NumSlr     = 3,
  parameter int unsigned IdleCycles = 16,
  parameter int unsigned HbTimeout  = 512,
  parameter int unsigned CmdW       = 44,
  parameter int unsigned CmdDepth   = 4,
  parameter int unsigned IssueGap   = 4
) (
  input  logic                icap_clk_i,
  input  logic                reset_i,
  input  logic                sem_en_i,
  input  logic                sem_cap_req_i,
  output logic                sem_cap_gnt_o,
  output logic                sem_cap_rel_o,
  output logic                icap_req_o,
  input  logic                icap_gnt_i,
  input  logic                icap_rel_i,
  input  logic [StatusW-1:0]  sem_status_i,
  input  logic [NumSlr-1:0]   slr_heartbeat_i,
  input  logic                hb_clear_i,
  output logic [NumSlr-1:0]   hb_lost_o,
  input  logic                cmd_valid_i,
  input  logic [CmdW-1:0]     cmd_code_i,
  output logic                cmd_ready_o,
  output logic                sem_command_strobe_o,
  output logic [CmdW-1:0]     sem_command_code_o,
  input  logic                sem_command_busy_i,
  output logic                idle_flag_o,
  output logic [1:0]          owner_state_o
);

  localparam int unsigned IdleW = $clog2(IdleCycles + 1);
  localparam int unsigned GapW  = $clog2(IssueGap);
  localparam int unsigned HbW   = $clog2(HbTimeout + 1);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(IdleCycles);
  localparam logic [GapW-1:0]  GapReload = GapW'(IssueGap - 1);
  localparam logic [HbW-1:0]   HbMax     = HbW'(HbTimeout);

  own_state_e state_q, state_d;
  logic       icap_req;
  logic       obs, quiet_ok, idle;

  assign obs      = sem_status_i[StObservation];
  // States in which SEM is not touching configuration memory in a way that must not be interrupted.
  assign quiet_ok = obs || sem_status_i[StDetectOnly];

  // ---------------- Ownership FSM ----------------
  always_comb begin
    state_d  = state_q;
    icap_req = 1'b0;
    case (state_q)
      OwnIdle: begin
        if (sem_en_i && sem_cap_req_i) state_d = OwnReq;
      end
      OwnReq: begin
        icap_req = 1'b1;
        // A cancel beats a grant arriving in the same cycle.
        if (!sem_en_i || !sem_cap_req_i) state_d = OwnIdle;
        else if (icap_gnt_i)             state_d = OwnHeld;
      end
      OwnHeld: begin
        // sem_en only gates new requests; it does not revoke ownership.
        icap_req = sem_cap_req_i;
        if (!sem_cap_req_i) state_d = OwnIdle;
      end
      default: state_d = OwnIdle;
    endcase
  end

  always_ff @(posedge icap_clk_i) begin
    if (reset_i) state_q <= OwnIdle;
    else         state_q <= state_d;
  end

  assign icap_req_o    = icap_req;
  assign sem_cap_gnt_o = icap_gnt_i;
  assign owner_state_o = state_q;

  // ---------------- Idle detect and release ----------------
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             idle_flag_q, sem_cap_rel_q;

  assign idle = ~|sem_status_i && icap_gnt_i && icap_req;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!idle)                     idle_cnt_d = '0;
    else if (idle_cnt_q != IdleMax) idle_cnt_d = idle_cnt_q + IdleW'(1);
  end

  always_ff @(posedge icap_clk_i) begin
    if (reset_i) begin
      idle_cnt_q    <= '0;
      idle_flag_q   <= 1'b0;
      sem_cap_rel_q <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      // Gated by idle so any activity drops the flag on the very next cycle.
      idle_flag_q   <= idle && (idle_cnt_q == IdleMax);
      sem_cap_rel_q <= (state_q == OwnHeld) && icap_rel_i &&
                       (quiet_ok || sem_status_i[StDiagScan] || idle_flag_q);
    end
  end

  assign idle_flag_o   = idle_flag_q;
  assign sem_cap_rel_o = sem_cap_rel_q && (state_q == OwnHeld);

  // ---------------- Command queue and issue ----------------
  logic            fifo_full, fifo_empty, issue;
  logic [CmdW-1:0] fifo_rdata, cmd_code_q;
  logic [GapW-1:0] gap_q;
  logic            strobe_q;

  assign cmd_ready_o = !fifo_full;
  assign issue = !fifo_empty && !sem_command_busy_i && (gap_q == '0) &&
                 (quiet_ok || idle_flag_q);

  sem_cmd_fifo #(
    .Width (CmdW),
    .Depth (CmdDepth)
  ) u_cmd_fifo (
    .clk_i   (icap_clk_i),
    .reset_i (reset_i),
    .push_i  (cmd_valid_i && !fifo_full),
    .wdata_i (cmd_code_i),
    .pop_i   (issue),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge icap_clk_i) begin
    if (reset_i) begin
      strobe_q   <= 1'b0;
      cmd_code_q <= '0;
      gap_q      <= '0;
    end else begin
      strobe_q <= issue;
      if (issue) begin
        cmd_code_q <= fifo_rdata;
        gap_q      <= GapReload;
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GapW'(1);
      end
    end
  end

  assign sem_command_strobe_o = strobe_q;
  assign sem_command_code_o   = cmd_code_q;

  // ---------------- Per-SLR heartbeat watchdog ----------------
  for (genvar g = 0; g < NumSlr; g++) begin : g_hb
    logic [HbW-1:0] cnt_q, cnt_d;
    logic           lost_q;

    always_comb begin
      cnt_d = cnt_q;
      if (slr_heartbeat_i[g])          cnt_d = '0;
      else if (obs && cnt_q != HbMax)  cnt_d = cnt_q + HbW'(1);
    end

    // hb_clear has priority so it wins over a timeout landing in the same cycle.
    always_ff @(posedge icap_clk_i) begin
      if (reset_i || hb_clear_i) begin
        cnt_q  <= '0;
        lost_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (cnt_d == HbMax) lost_q <= 1'b1;
      end
    end

    assign hb_lost_o[g] = lost_q;
  end

endmodule

// File: tb/tb_sem_icap_handoff.sv
// Self-checking bench for sem_icap_handoff: directed scenarios plus a randomized
// run against a behavioural reference model.
module tb_sem_icap_handoff;

  localparam int NumSlr     = 3;
  localparam int IdleCycles = 16;
  localparam int HbTimeout  = 512;
  localparam int CmdW       = 44;
  localparam int CmdDepth   = 4;
  localparam int IssueGap   = 4;

  logic              clk;
  logic              reset;
  logic              sem_en, sem_cap_req, sem_cap_gnt, sem_cap_rel;
  logic              icap_req, icap_gnt, icap_rel;
  logic [8:0]        sem_status;
  logic [NumSlr-1:0] slr_heartbeat, hb_lost;
  logic              hb_clear;
  logic              cmd_valid, cmd_ready;
  logic [CmdW-1:0]   cmd_code, sem_command_code;
  logic              sem_command_strobe, sem_command_busy;
  logic              idle_flag;
  logic [1:0]        owner_state;

  int errors = 0;
  int checks = 0;

  sem_icap_handoff #(
    .NumSlr     (NumSlr),
    .IdleCycles (IdleCycles),
    .HbTimeout  (HbTimeout),
    .CmdW       (CmdW),
    .CmdDepth   (CmdDepth),
    .IssueGap   (IssueGap)
  ) dut (
    .icap_clk_i           (clk),
    .reset_i              (reset),
    .sem_en_i             (sem_en),
    .sem_cap_req_i        (sem_cap_req),
    .sem_cap_gnt_o        (sem_cap_gnt),
    .sem_cap_rel_o        (sem_cap_rel),
    .icap_req_o           (icap_req),
    .icap_gnt_i           (icap_gnt),
    .icap_rel_i           (icap_rel),
    .sem_status_i         (sem_status),
    .slr_heartbeat_i      (slr_heartbeat),
    .hb_clear_i           (hb_clear),
    .hb_lost_o            (hb_lost),
    .cmd_valid_i          (cmd_valid),
    .cmd_code_i           (cmd_code),
    .cmd_ready_o          (cmd_ready),
    .sem_command_strobe_o (sem_command_strobe),
    .sem_command_code_o   (sem_command_code),
    .sem_command_busy_i   (sem_command_busy),
    .idle_flag_o          (idle_flag),
    .owner_state_o        (owner_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- Reference model ----------------
  // Ownership: 0 idle, 1 requesting, 2 owned.
  int              m_state;
  int              m_idle_run;   // consecutive idle cycles seen so far
  bit              m_flag, m_rel, m_strobe;
  logic [CmdW-1:0] m_q[$];
  logic [CmdW-1:0] m_code;
  int              m_gap;        // cycles still to wait before next issue
  int              m_silent[NumSlr];
  logic [NumSlr-1:0] m_lost;

  task automatic model_step();
    bit obs, det, diag, req_now, idle_now, issue, accept;
    int nstate;
    if (reset) begin
      m_state = 0; m_idle_run = 0; m_flag = 0; m_rel = 0; m_strobe = 0;
      m_q.delete(); m_code = '0; m_gap = 0; m_lost = '0;
      for (int i = 0; i < NumSlr; i++) m_silent[i] = 0;
      return;
    end
    obs  = sem_status[1];
    diag = sem_status[7];
    det  = sem_status[8];
    req_now  = (m_state == 1) || (m_state == 2 && sem_cap_req);
    idle_now = (sem_status == 9'd0) && icap_gnt && req_now;
    nstate = m_state;
    if (m_state == 0 && sem_en && sem_cap_req) nstate = 1;
    else if (m_state == 1) nstate = (!sem_en || !sem_cap_req) ? 0 : (icap_gnt ? 2 : 1);
    else if (m_state == 2 && !sem_cap_req) nstate = 0;

    m_rel  = (m_state == 2) && icap_rel && (obs || diag || det || m_flag);
    issue  = (m_q.size() > 0) && !sem_command_busy && (m_gap == 0) && (obs || det || m_flag);
    accept = cmd_valid && (m_q.size() < CmdDepth);
    m_flag = idle_now && (m_idle_run >= IdleCycles);
    m_idle_run = idle_now ? ((m_idle_run < 1000) ? m_idle_run + 1 : m_idle_run) : 0;
    m_strobe = issue;
    if (issue) begin
      m_code = m_q.pop_front();
      m_gap  = IssueGap - 1;
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end
    if (accept) m_q.push_back(cmd_code);
    if (hb_clear) begin
      m_lost = '0;
      for (int i = 0; i < NumSlr; i++) m_silent[i] = 0;
    end else begin
      for (int i = 0; i < NumSlr; i++) begin
        if (slr_heartbeat[i])                     m_silent[i] = 0;
        else if (obs && m_silent[i] < HbTimeout)  m_silent[i] = m_silent[i] + 1;
        if (m_silent[i] == HbTimeout) m_lost[i] = 1'b1;
      end
    end
    m_state = nstate;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sem_en = 0; sem_cap_req = 0; icap_gnt = 0; icap_rel = 0; sem_status = '0;
    slr_heartbeat = '0; hb_clear = 0; cmd_valid = 0; cmd_code = '0; sem_command_busy = 0;
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    cycle(); cycle();
    checks++; if (owner_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", owner_state); end
    checks++; if (icap_req !== 1'b0) begin errors++; $display("FAIL reset_icap_req: got %b want 0", icap_req); end
    checks++; if (sem_cap_rel !== 1'b0) begin errors++; $display("FAIL reset_rel: got %b want 0", sem_cap_rel); end
    checks++; if (idle_flag !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b want 0", idle_flag); end
    checks++; if (hb_lost !== 3'b000) begin errors++; $display("FAIL reset_hb_lost: got %b want 000", hb_lost); end
    checks++; if (sem_command_strobe !== 1'b0 || sem_command_code !== '0) begin
      errors++; $display("FAIL reset_cmd: got strobe=%b code=%h want 0/0", sem_command_strobe, sem_command_code);
    end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    reset = 0;
  endtask

  task automatic test_ownership();
    sem_en = 1; sem_cap_req = 1; icap_gnt = 0;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checks++; if (owner_state !== 2'b01 || icap_req !== 1'b1) begin
        errors++; $display("FAIL acquire_req%0d: got state=%b req=%b want 01/1", i, owner_state, icap_req);
      end
    end
    icap_gnt = 1;
    cycle();
    checks++; if (owner_state !== 2'b10 || icap_req !== 1'b1 || sem_cap_gnt !== 1'b1) begin
      errors++; $display("FAIL acquire_own: got state=%b req=%b gnt=%b want 10/1/1", owner_state, icap_req, sem_cap_gnt);
    end
    sem_cap_req = 0;
    cycle();
    checks++; if (owner_state !== 2'b00 || icap_req !== 1'b0) begin
      errors++; $display("FAIL drop_req: got state=%b req=%b want 00/0", owner_state, icap_req);
    end
    sem_cap_req = 1; icap_gnt = 0;
    cycle();
    sem_en = 0; icap_gnt = 1;
    cycle();
    checks++; if (owner_state !== 2'b00 || icap_req !== 1'b0) begin
      errors++; $display("FAIL cancel_beats_gnt: got state=%b req=%b want 00/0", owner_state, icap_req);
    end
    sem_en = 1;
    cycle(); cycle();
    sem_en = 0;
    cycle();
    checks++; if (owner_state !== 2'b10) begin
      errors++; $display("FAIL en_no_revoke: got state=%b want 10", owner_state);
    end
  endtask

  task automatic test_idle_release();
    sem_status = 9'b1;
    cycle();
    sem_status = '0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++; if (idle_flag !== (k >= IdleCycles + 1)) begin
        errors++; $display("FAIL idle_flag_k%0d: got %b want %b", k, idle_flag, k >= IdleCycles + 1);
      end
    end
    sem_status = 9'b100;
    cycle();
    checks++; if (idle_flag !== 1'b0) begin errors++; $display("FAIL idle_clear: got %b want 0", idle_flag); end
    icap_rel = 1;
    cycle();
    checks++; if (sem_cap_rel !== 1'b0) begin errors++; $display("FAIL rel_correction: got %b want 0", sem_cap_rel); end
    sem_status = 9'b10;
    cycle();
    checks++; if (sem_cap_rel !== 1'b1) begin errors++; $display("FAIL rel_observation: got %b want 1", sem_cap_rel); end
    icap_rel = 0;
    cycle();
    checks++; if (sem_cap_rel !== 1'b0) begin errors++; $display("FAIL rel_drop: got %b want 0", sem_cap_rel); end
    icap_rel = 1; sem_cap_req = 0;
    cycle();
    checks++; if (sem_cap_rel !== 1'b0 || owner_state !== 2'b00) begin
      errors++; $display("FAIL rel_not_owned: got rel=%b state=%b want 0/00", sem_cap_rel, owner_state);
    end
    icap_rel = 0; sem_status = '0;
  endtask

  task automatic test_fifo_issue();
    int strobe_t[$];
    logic [CmdW-1:0] strobe_c[$];
    sem_command_busy = 1;
    for (int i = 1; i <= 5; i++) begin
      checks++; if (cmd_ready !== (i <= CmdDepth)) begin
        errors++; $display("FAIL ready_before_push%0d: got %b want %b", i, cmd_ready, i <= CmdDepth);
      end
      cmd_valid = 1; cmd_code = CmdW'(i);
      cycle();
    end
    cmd_valid = 0;
    sem_command_busy = 0; sem_status = 9'b10;
    for (int t = 1; t <= 40; t++) begin
      cycle();
      if (sem_command_strobe === 1'b1) begin
        strobe_t.push_back(t);
        strobe_c.push_back(sem_command_code);
      end
    end
    checks++; if (strobe_t.size() != 4) begin
      errors++; $display("FAIL strobe_count: got %0d want 4", strobe_t.size());
    end
    for (int i = 0; i < strobe_t.size() && i < 4; i++) begin
      checks++; if (strobe_c[i] !== CmdW'(i + 1)) begin
        errors++; $display("FAIL strobe_code%0d: got %h want %h", i, strobe_c[i], i + 1);
      end
      if (i > 0) begin
        checks++; if (strobe_t[i] - strobe_t[i-1] != IssueGap) begin
          errors++; $display("FAIL strobe_gap%0d: got %0d want %0d", i, strobe_t[i] - strobe_t[i-1], IssueGap);
        end
      end
    end
    checks++; if (sem_command_code !== CmdW'(4) || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL code_hold: got code=%h ready=%b want 4/1", sem_command_code, cmd_ready);
    end
  endtask

  task automatic test_watchdog();
    int bad;
    sem_status = 9'b10;
    hb_clear = 1;
    cycle();
    hb_clear = 0;
    bad = 0;
    for (int k = 1; k <= HbTimeout + 8; k++) begin
      slr_heartbeat = (k % 10 == 0) ? 3'b101 : 3'b000;
      cycle();
      checks++; if (hb_lost !== ((k >= HbTimeout) ? 3'b010 : 3'b000)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL hb_lost_k%0d: got %b want %b", k, hb_lost, (k >= HbTimeout) ? 3'b010 : 3'b000);
      end
    end
    slr_heartbeat = '0; hb_clear = 1;
    cycle();
    checks++; if (hb_lost !== 3'b000) begin errors++; $display("FAIL hb_clear: got %b want 000", hb_lost); end
    hb_clear = 0;
    for (int k = 1; k < HbTimeout; k++) cycle();
    checks++; if (hb_lost !== 3'b000) begin errors++; $display("FAIL hb_pre_timeout: got %b want 000", hb_lost); end
    hb_clear = 1;
    cycle();
    checks++; if (hb_lost !== 3'b000) begin errors++; $display("FAIL hb_clear_wins: got %b want 000", hb_lost); end
    hb_clear = 0;
    cycle();
    checks++; if (hb_lost !== 3'b000) begin errors++; $display("FAIL hb_after_clear: got %b want 000", hb_lost); end
    sem_status = '0;
  endtask

  task automatic test_reset_mid();
    int extra;
    sem_en = 1; sem_cap_req = 1; icap_gnt = 1; sem_status = '0; sem_command_busy = 1;
    cycle(); cycle();
    cmd_valid = 1; cmd_code = CmdW'(44'hA5); cycle();
    cmd_code = CmdW'(44'h5A); cycle();
    cmd_valid = 0; sem_command_busy = 0; sem_status = 9'b10;
    cycle();
    checks++; if (sem_command_strobe !== 1'b1 || sem_command_code !== CmdW'(44'hA5)) begin
      errors++; $display("FAIL mid_first_strobe: got %b/%h want 1/a5", sem_command_strobe, sem_command_code);
    end
    reset = 1;
    cycle();
    reset = 0;
    checks++; if (owner_state !== 2'b00 || icap_req !== 1'b0 || sem_command_strobe !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got state=%b req=%b strobe=%b ready=%b want 00/0/0/1",
                        owner_state, icap_req, sem_command_strobe, cmd_ready);
    end
    extra = 0;
    for (int t = 0; t < 12; t++) begin
      cycle();
      if (sem_command_strobe === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL mid_discard: got %0d strobes want 0", extra); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [55:0] got, exp;
    int bad, r;
    reset = 1; cycle(); reset = 0;
    bad = 0;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) sem_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) sem_cap_req = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 9) == 0) icap_gnt = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) icap_rel = $urandom_range(0, 1);
      if ($urandom_range(0, 11) == 0) begin
        r = $urandom_range(0, 9);
        case (r)
          5:       sem_status = 9'b000000010;
          6:       sem_status = 9'b000000100;
          7:       sem_status = 9'b100000000;
          8:       sem_status = 9'b010000000;
          9:       sem_status = 9'($urandom);
          default: sem_status = '0;
        endcase
      end
      for (int i = 0; i < NumSlr; i++) slr_heartbeat[i] = ($urandom_range(0, 199) == 0);
      hb_clear  = ($urandom_range(0, 499) == 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_code  = CmdW'({$urandom, $urandom});
      if ($urandom_range(0, 4) == 0) sem_command_busy = ($urandom_range(0, 3) == 0);
      cycle();
      exp = {2'(m_state), (m_state == 1) || (m_state == 2 && sem_cap_req), icap_gnt,
             m_rel && (m_state == 2), m_flag, (m_q.size() < CmdDepth), m_strobe, m_code, m_lost};
      got = {owner_state, icap_req, sem_cap_gnt, sem_cap_rel, idle_flag, cmd_ready,
             sem_command_strobe, sem_command_code, hb_lost};
      checks++; if (got !== exp) begin
        errors++; bad++;
        if (bad < 6) $display("FAIL random_cycle%0d: got %h want %h", n, got, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_ownership();
    test_idle_release();
    test_fifo_issue();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
